ads131_spi_frame_master: RTL
============================

Name: ads131_spi_frame_master

Overview:
Parametrised SPI frame engine for the ADS131A0X. It is the successor to the fixed 32-bit, single-message SPI master. It shifts a full device frame of NUM_WORDS words of WORD_BITS each, with the clock mode selectable. It exposes a start/busy/done handshake, streams each received word as it completes, and generates the ADC hardware reset pulse on request. It sits between the ADC command/readout sequencer and the ADC pins, all in the system_clock domain.

Parameters:
WORD_BITS, 24, device word size; legal values 16, 24, 32.
NUM_WORDS, 5, words per frame (status word + 4 channels).
CLK_DIV, 6, system_clock cycles per SCLK half-period (50 MHz / 12 = 4.167 MHz); minimum 2.
CPHA, 1, 1 = launch on SCLK rise, sample on fall; 0 = sample on rise, launch on fall. CPOL is fixed at 0.
CS_SETUP_CYCLES, 2, cycles from SPI_CS falling to SHIFT entry; minimum 1.
CS_HOLD_CYCLES, 2, cycles from last SCLK edge to SPI_CS rising; minimum 1.
CS_GAP_CYCLES, 4, minimum cycles with SPI_CS high before the next frame; minimum 1.
RESET_CYCLES, 250, length of the SPI_RESET low pulse in cycles.

Ports:
system_clock  in  1  sole clock, 50 MHz.
reset  in  1  synchronous, active-high reset.
start  in  1  request a frame; accepted only when busy=0.
tx_frame  in  NUM_WORDS*WORD_BITS  frame to send; word 0 in MSBs; latched when start is accepted.
adc_reset_req  in  1  request the ADC reset pulse; accepted only when busy=0.
busy  out  1  engine active.
done  out  1  one-cycle pulse at the end of a frame or reset pulse.
rx_word_valid  out  1  one-cycle pulse for each completed received word.
rx_word  out  WORD_BITS  received word; valid with rx_word_valid.
rx_word_index  out  $clog2(NUM_WORDS)  index of rx_word, 0 = status word.
rx_frame  out  NUM_WORDS*WORD_BITS  whole received frame; updated in the cycle done rises.
SPI_MOSI  out  1  serial data out.
SPI_MISO  in  1  serial data in.
SPI_CS  out  1  chip select, active low.
SPI_SCLK  out  1  serial clock, idles low.
SPI_RESET  out  1  ADC reset, active low.

Behaviour:
- Reset (synchronous, active-high). Next edge: state=IDLE, SPI_CS=1, SPI_SCLK=0, SPI_MOSI=0, SPI_RESET=1, busy=0, done=0, rx_word_valid=0, rx_word=0, rx_frame=0, counters=0. A reset mid-frame aborts the frame immediately, with no done and no partial rx_word_valid.
- States: IDLE, ADC_RST, CS_SETUP, SHIFT, CS_HOLD, GAP.
- IDLE:
  - adc_reset_req=1 → ADC_RST. adc_reset_req wins if it arrives together with start.
  - else start=1 → CS_SETUP; tx_frame is latched in the same cycle.
  - busy goes high the cycle after acceptance.
  - start or adc_reset_req while busy=1 is ignored and not queued.
- ADC_RST: SPI_RESET=0 for exactly RESET_CYCLES cycles, SPI_CS=1. Then done pulses, SPI_RESET=1, and the state returns to IDLE.
- CS_SETUP: SPI_CS=0 from the cycle after acceptance. Lasts CS_SETUP_CYCLES cycles, then SHIFT. For CPHA=0, SPI_MOSI holds bit 0 (the MSB of word 0) throughout CS_SETUP.
- SHIFT:
  - The half-period counter counts 0..CLK_DIV-1; SPI_SCLK toggles at terminal count. The first rising edge occurs CLK_DIV cycles after SHIFT entry.
  - Exactly NUM_WORDS*WORD_BITS rising edges and the same number of falling edges per frame.
  - CPHA=1: MOSI bit n is updated in the cycle of rising edge n; MISO is sampled in the cycle of falling edge n.
  - CPHA=0: MISO is sampled at rising edge n; MOSI advances at falling edge n, except after the last bit.
  - Bits go MSB first, word 0 first.
  - After the sample of each word's last bit: rx_word_valid=1 for one cycle on the next cycle, with rx_word and rx_word_index set.
  - After the final edge (SCLK low) → CS_HOLD.
- CS_HOLD: SPI_CS stays 0 and SPI_SCLK=0 for CS_HOLD_CYCLES cycles, then SPI_CS=1 → GAP.
- GAP: SPI_CS=1 and SPI_MOSI=0 for CS_GAP_CYCLES cycles. done pulses in the last GAP cycle, with rx_frame updated in the same cycle. busy=0 the next cycle, which is IDLE.
- Frame duration from accept to done: CS_SETUP_CYCLES + 2*CLK_DIV*NUM_WORDS*WORD_BITS + CS_HOLD_CYCLES + CS_GAP_CYCLES, ±1 cycle, which must be fixed in the implementation and asserted.
- Bit counter wraps per word (0..WORD_BITS-1). The word counter saturates at NUM_WORDS-1; no wrap within a frame.
- tx_frame changes while busy have no effect.

Decomposition:
- Package ads131_spi_pkg holds:
  - state enum;
  - command constants: NULL 16'h0000, RESET 16'h0011, UNLOCK 16'h0655, WAKEUP 16'h0033;
  - READY status 16'hFF04;
  - a helper that left-aligns a 16-bit command into WORD_BITS.
- Sub-module ads131_sclk_gen: half-period counter, SCLK register, and single-cycle rise/fall strobes; enabled only in SHIFT.

Test Plan:
1. Defaults (WORD_BITS=24, NUM_WORDS=5, CLK_DIV=6, CPHA=1); start with word0=24'h065500, others 0; MISO model returns 24'hFF0400, 24'h000001..24'h000004 → 120 rising edges, SCLK high and low each 6 cycles, MOSI decodes 24'h065500; rx_word_valid pulses 5 times with indices 0..4; rx_frame = {FF0400, 000001, 000002, 000003, 000004}; exactly one done.
2. CS timing: measure SPI_CS fall to first SCLK rise ≥ 2+6 cycles, last SCLK fall to SPI_CS rise = 2 cycles, SPI_CS high ≥ 4 cycles between two back-to-back frames with start held high.
3. adc_reset_req and start asserted together in IDLE → SPI_RESET low exactly 250 cycles, SPI_CS stays 1, done once, the start is dropped.
4. start pulsed mid-frame and tx_frame changed mid-frame → no second frame; MOSI still carries the originally latched data.
5. reset asserted at bit 37 → next edge SPI_CS=1, SCLK=0, busy=0, no done and no further rx_word_valid; a new start afterwards completes correctly.
6. CPHA=0, WORD_BITS=16, NUM_WORDS=2, tx {16'h0011, 16'h0000} → MSB on MOSI before the first rise, sampling on rises; rx matches MISO model {16'hFF04, 16'hABCD}.

Source files
------------

// File: rtl/ads131_spi_pkg.sv
// Shared types and ADS131A0X command words for the SPI frame engine.
package ads131_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADC_RST,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP
  } state_e;

  localparam logic [15:0] CMD_NULL     = 16'h0000;
  localparam logic [15:0] CMD_RESET    = 16'h0011;
  localparam logic [15:0] CMD_UNLOCK   = 16'h0655;
  localparam logic [15:0] CMD_WAKEUP   = 16'h0033;
  localparam logic [15:0] READY_STATUS = 16'hFF04;

  // Left-aligns a 16-bit command in a word_bits-wide word; result sits in the low word_bits bits.
  function automatic logic [31:0] cmd_word(input logic [15:0] cmd, input int unsigned word_bits);
    return {cmd, 16'h0000} >> (32 - word_bits);
  endfunction

endpackage

// File: rtl/ads131_sclk_gen.sv
// SCLK generator: half-period counter with single-cycle strobes marking the cycle of each SCLK edge.
module ads131_sclk_gen #(
  parameter int CLK_DIV = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int HW = $clog2(CLK_DIV);
  localparam logic [HW-1:0] HC_TC = HW'(CLK_DIV - 1);

  logic [HW-1:0] hc_q;
  logic          sclk_q;
  logic          tc;

  assign tc     = en_i && (hc_q == HC_TC);
  assign rise_o = tc && !sclk_q;
  assign fall_o = tc && sclk_q;
  assign sclk_o = sclk_q;

  // Disabled outside SHIFT so every frame starts from a full half-period with SCLK low.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      hc_q   <= '0;
      sclk_q <= 1'b0;
    end else if (tc) begin
      hc_q   <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      hc_q <= hc_q + 1'b1;
    end
  end

endmodule

// File: rtl/ads131_spi_frame_master.sv
// ADS131A0X SPI frame engine: shifts NUM_WORDS x WORD_BITS frames, streams rx words, drives the ADC reset pulse.
module ads131_spi_frame_master
  import ads131_spi_pkg::*;
#(
  parameter int WORD_BITS       = 24,
  parameter int NUM_WORDS       = 5,
  parameter int CLK_DIV         = 6,
  parameter int CPHA            = 1,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int CS_GAP_CYCLES   = 4,
  parameter int RESET_CYCLES    = 250,
  localparam int FRAME_BITS = NUM_WORDS * WORD_BITS,
  localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_frame,
  input  logic                  adc_reset_req,
  output logic                  busy,
  output logic                  done,
  output logic                  rx_word_valid,
  output logic [WORD_BITS-1:0]  rx_word,
  output logic [IDX_W-1:0]      rx_word_index,
  output logic [FRAME_BITS-1:0] rx_frame,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO,
  output logic                  SPI_CS,
  output logic                  SPI_SCLK,
  output logic                  SPI_RESET
);
  localparam int CMAX_A = (RESET_CYCLES > CS_SETUP_CYCLES) ? RESET_CYCLES : CS_SETUP_CYCLES;
  localparam int CMAX_B = (CS_HOLD_CYCLES > CS_GAP_CYCLES) ? CS_HOLD_CYCLES : CS_GAP_CYCLES;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CNT_W  = $clog2(CMAX + 1);
  localparam int BIT_W  = $clog2(WORD_BITS);

  localparam logic [CNT_W-1:0] RST_TC   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(CS_GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_TC   = BIT_W'(WORD_BITS - 1);
  localparam logic [IDX_W-1:0] WORD_TC  = IDX_W'(NUM_WORDS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cs_q, rstn_q, busy_q, done_q;
  logic [FRAME_BITS-1:0] tx_q, rx_acc_q, rx_frame_q;
  logic [WORD_BITS-1:0]  rx_word_q;
  logic [IDX_W-1:0]      rx_idx_q, word_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  rv_q, mosi_q, fin_q;
  logic                  sclk, rise, fall;
  logic                  accept, samp, launch, last_edge, bit_last, word_last, frame_done, done_d;

  ads131_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk_i  (system_clock),
    .rst_i  (reset),
    .en_i   (state_q == ST_SHIFT),
    .sclk_o (sclk),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign accept    = (state_q == ST_IDLE) && start && !adc_reset_req;
  assign bit_last  = (bit_q == BIT_TC);
  assign word_last = (word_q == WORD_TC);
  assign samp      = (CPHA != 0) ? fall : rise;
  // With CPHA=0 the last sample precedes the last fall, so a flag remembers it.
  assign last_edge = fall && ((CPHA != 0) ? (word_last && bit_last) : fin_q);
  assign launch    = (CPHA != 0) ? rise : (fall && !last_edge);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE:
        if (adc_reset_req)  state_d = ST_ADC_RST;
        else if (start)     state_d = ST_CS_SETUP;
      ST_ADC_RST:
        if (cnt_q == RST_TC) state_d = ST_IDLE;
        else                 cnt_d   = cnt_q + 1'b1;
      ST_CS_SETUP:
        if (cnt_q == SETUP_TC) state_d = ST_SHIFT;
        else                   cnt_d   = cnt_q + 1'b1;
      ST_SHIFT:
        if (last_edge) state_d = ST_CS_HOLD;
      ST_CS_HOLD:
        if (cnt_q == HOLD_TC) state_d = ST_GAP;
        else                  cnt_d   = cnt_q + 1'b1;
      ST_GAP:
        if (cnt_q == GAP_TC) state_d = ST_IDLE;
        else                 cnt_d   = cnt_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_done = (state_d == ST_GAP) && (cnt_d == GAP_TC);
  assign done_d     = frame_done || ((state_q == ST_ADC_RST) && (cnt_q == RST_TC));

  // Pin and handshake outputs are registered from the next state so they change cleanly with it.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      rstn_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= !(state_d inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
      rstn_q  <= (state_d != ST_ADC_RST);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      tx_q       <= '0;
      rx_acc_q   <= '0;
      rx_frame_q <= '0;
      rx_word_q  <= '0;
      rx_idx_q   <= '0;
      rv_q       <= 1'b0;
      mosi_q     <= 1'b0;
      bit_q      <= '0;
      word_q     <= '0;
      fin_q      <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      // CPHA=0 presents the first bit already during CS setup.
      if (accept) begin
        tx_q     <= (CPHA != 0) ? tx_frame : (tx_frame << 1);
        mosi_q   <= (CPHA != 0) ? 1'b0 : tx_frame[FRAME_BITS-1];
        bit_q    <= '0;
        word_q   <= '0;
        fin_q    <= 1'b0;
        rx_acc_q <= '0;
      end else if (state_d inside {ST_IDLE, ST_ADC_RST, ST_GAP}) begin
        mosi_q <= 1'b0;
      end else if (launch) begin
        mosi_q <= tx_q[FRAME_BITS-1];
        tx_q   <= tx_q << 1;
      end
      if (samp) begin
        rx_acc_q <= {rx_acc_q[FRAME_BITS-2:0], SPI_MISO};
        if (bit_last) begin
          bit_q     <= '0;
          rv_q      <= 1'b1;
          rx_word_q <= {rx_acc_q[WORD_BITS-2:0], SPI_MISO};
          rx_idx_q  <= word_q;
          if (word_last) fin_q  <= 1'b1;
          else           word_q <= word_q + 1'b1;
        end else begin
          bit_q <= bit_q + 1'b1;
        end
      end
      if (frame_done) rx_frame_q <= rx_acc_q;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rx_word_valid = rv_q;
  assign rx_word       = rx_word_q;
  assign rx_word_index = rx_idx_q;
  assign rx_frame      = rx_frame_q;
  assign SPI_MOSI      = mosi_q;
  assign SPI_CS        = cs_q;
  assign SPI_SCLK      = sclk;
  assign SPI_RESET     = rstn_q;

endmodule
